hdmi_period_scheduler: RTL and testbench

// Sequences the three per-channel tmds_encoder instances (ch0=blue, ch1=green, ch2=red) for HDMI video output.

---
 rtl/hdmi_period_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler
//   Sequences the three TMDS channel encoders (ch0=blue, ch1=green, ch2=red) for HDMI output.
//   The incoming timing/pixel stream is delayed by a fixed 11 cycles so that an 8-character
//   video preamble (CTL0..3 = 1,0,0,0) and a 2-character leading guard band can be inserted
//   ahead of each active line, provided the blanking before the line was long enough.
//
// Parameters
//   DVI_MODE   1 = DVI sink: never insert preamble/guard, CTL1..3 held 0, same latency
//   MIN_BLANK  blanking run (cycles, 10..255) needed before a DE rise to insert preamble+guard
//
// Ports
//   clk, resetn               pixel clock, synchronous active-low reset
//   vid_de/hsync/vsync        timing from the video generator
//   vid_r/g/b                 pixel components
//   clr_err                   clears err_short_blank
//   enc_de, enc_d0/d1/d2      DE and data for the ch0/ch1/ch2 encoders (b/g/r), data 0 when DE=0
//   enc_ctl                   {ch2 C1,C0, ch1 C1,C0, ch0 C1=vsync, C0=hsync}
//   guard_valid, guard_sym*   guard band character strobe and its constant symbols
//   state_o                   0=CTRL 1=PREAMBLE 2=GUARD 3=VIDEO (aligned with outputs)
//   err_short_blank           sticky: a DE rise followed fewer than MIN_BLANK blank cycles

module hdmi_period_scheduler #(
   parameter int unsigned DVI_MODE  = 0,
   parameter int unsigned MIN_BLANK = 12
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       vid_de,
   input  logic       vid_hsync,
   input  logic       vid_vsync,
   input  logic [7:0] vid_r,
   input  logic [7:0] vid_g,
   input  logic [7:0] vid_b,
   input  logic       clr_err,
   output logic       enc_de,
   output logic [7:0] enc_d0,
   output logic [7:0] enc_d1,
   output logic [7:0] enc_d2,
   output logic [5:0] enc_ctl,
   output logic       guard_valid,
   output logic [9:0] guard_sym0,
   output logic [9:0] guard_sym1,
   output logic [9:0] guard_sym2,
   output logic [1:0] state_o,
   output logic       err_short_blank
);

   localparam int unsigned Depth    = 10;
   localparam logic [7:0]  MinBlank = 8'(MIN_BLANK);
   localparam logic        DviMode  = (DVI_MODE != 0);

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } vid_t;

   typedef enum logic [1:0] {
      StCtrl     = 2'd0,
      StPreamble = 2'd1,
      StGuard    = 2'd2,
      StVideo    = 2'd3
   } state_e;

   vid_t       dly_q [Depth];
   vid_t       cur;
   vid_t       tail;
   logic [7:0] blank_q, blank_d;
   state_e     state_q, state_d;
   logic [2:0] pcnt_q, pcnt_d;
   logic       err_q, err_d;
   logic       enc_de_q, enc_de_d;
   logic [7:0] enc_d0_q, enc_d0_d;
   logic [7:0] enc_d1_q, enc_d1_d;
   logic [7:0] enc_d2_q, enc_d2_d;
   logic [5:0] enc_ctl_q, enc_ctl_d;
   logic       guard_q, guard_d;
   logic       de_rise;
   logic       long_blank;
   logic       start_pre;
   logic       short_rise;

   assign cur  = '{de: vid_de, hs: vid_hsync, vs: vid_vsync, r: vid_r, g: vid_g, b: vid_b};
   // Oldest delay stage: what the output register shows next cycle.
   assign tail = dly_q[Depth-1];

   // The previous input DE lives in the first delay stage; after reset it reads 0, so a DE held
   // high through reset counts as a rise with a zero blank count.
   assign de_rise    = vid_de & ~dly_q[0].de;
   assign long_blank = (blank_q >= MinBlank);
   assign start_pre  = de_rise & long_blank & ~DviMode;
   assign short_rise = de_rise & ~long_blank & ~DviMode;

   always_comb begin
      blank_d = blank_q;
      if (vid_de) begin
         blank_d = '0;
      end else if (blank_q != 8'hFF) begin
         blank_d = blank_q + 8'd1;
      end
   end

   // The DE rise is seen 11 cycles before the delayed pixel reaches the outputs, leaving exactly
   // 8 preamble + 2 guard cycles in front of it.
   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      if (start_pre) begin
         state_d = StPreamble;
         pcnt_d  = 3'd7;
      end else begin
         case (state_q)
            StPreamble: begin
               if (pcnt_q == 3'd0) begin
                  state_d = StGuard;
                  pcnt_d  = 3'd1;
               end else begin
                  pcnt_d = pcnt_q - 3'd1;
               end
            end
            StGuard: begin
               if (pcnt_q == 3'd0) begin
                  state_d = tail.de ? StVideo : StCtrl;
               end else begin
                  pcnt_d = pcnt_q - 3'd1;
               end
            end
            default: begin
               state_d = tail.de ? StVideo : StCtrl;
            end
         endcase
      end
   end

   always_comb begin
      enc_de_d  = (state_d == StVideo) & tail.de;
      enc_d0_d  = enc_de_d ? tail.b : 8'd0;
      enc_d1_d  = enc_de_d ? tail.g : 8'd0;
      enc_d2_d  = enc_de_d ? tail.r : 8'd0;
      enc_ctl_d = {4'b0000, tail.vs, tail.hs};
      if (state_d == StPreamble) begin
         enc_ctl_d[2] = 1'b1;  // ch1 C0
      end
      guard_d = (state_d == StGuard);
      // Set has priority over a simultaneous clear.
      err_d   = short_rise | (err_q & ~clr_err);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < Depth; i++) begin
            dly_q[i] <= '0;
         end
         blank_q   <= '0;
         state_q   <= StCtrl;
         pcnt_q    <= '0;
         err_q     <= 1'b0;
         enc_de_q  <= 1'b0;
         enc_d0_q  <= '0;
         enc_d1_q  <= '0;
         enc_d2_q  <= '0;
         enc_ctl_q <= '0;
         guard_q   <= 1'b0;
      end else begin
         dly_q[0] <= cur;
         for (int i = 1; i < Depth; i++) begin
            dly_q[i] <= dly_q[i-1];
         end
         blank_q   <= blank_d;
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         err_q     <= err_d;
         enc_de_q  <= enc_de_d;
         enc_d0_q  <= enc_d0_d;
         enc_d1_q  <= enc_d1_d;
         enc_d2_q  <= enc_d2_d;
         enc_ctl_q <= enc_ctl_d;
         guard_q   <= guard_d;
      end
   end

   assign enc_de          = enc_de_q;
   assign enc_d0          = enc_d0_q;
   assign enc_d1          = enc_d1_q;
   assign enc_d2          = enc_d2_q;
   assign enc_ctl         = enc_ctl_q;
   assign guard_valid     = guard_q;
   assign state_o         = state_q;
   assign err_short_blank = err_q;

   assign guard_sym0 = 10'b1011001100;
   assign guard_sym1 = 10'b0100110011;
   assign guard_sym2 = 10'b1011001100;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
module tb_hdmi_period_scheduler;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       vid_de = 1'b0, vid_hsync = 1'b0, vid_vsync = 1'b0, clr_err = 1'b0;
   logic [7:0] vid_r = '0, vid_g = '0, vid_b = '0;

   logic       a_de, a_gv, a_err, v_de, v_gv, v_err;
   logic [7:0] a_d0, a_d1, a_d2, v_d0, v_d1, v_d2;
   logic [5:0] a_ctl, v_ctl;
   logic [9:0] a_s0, a_s1, a_s2, v_s0, v_s1, v_s2;
   logic [1:0] a_st, v_st;

   always #5 clk = ~clk;

   hdmi_period_scheduler #(.DVI_MODE(0), .MIN_BLANK(12)) dut (
      .clk(clk), .resetn(resetn), .vid_de(vid_de), .vid_hsync(vid_hsync),
      .vid_vsync(vid_vsync), .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .clr_err(clr_err),
      .enc_de(a_de), .enc_d0(a_d0), .enc_d1(a_d1), .enc_d2(a_d2), .enc_ctl(a_ctl),
      .guard_valid(a_gv), .guard_sym0(a_s0), .guard_sym1(a_s1), .guard_sym2(a_s2),
      .state_o(a_st), .err_short_blank(a_err));

   hdmi_period_scheduler #(.DVI_MODE(1), .MIN_BLANK(12)) dut_dvi (
      .clk(clk), .resetn(resetn), .vid_de(vid_de), .vid_hsync(vid_hsync),
      .vid_vsync(vid_vsync), .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .clr_err(clr_err),
      .enc_de(v_de), .enc_d0(v_d0), .enc_d1(v_d1), .enc_d2(v_d2), .enc_ctl(v_ctl),
      .guard_valid(v_gv), .guard_sym0(v_s0), .guard_sym1(v_s1), .guard_sym2(v_s2),
      .state_o(v_st), .err_short_blank(v_err));

   // Input history: hist[10] is what the outputs must carry this cycle.
   int          cyc = 0;
   logic [26:0] hist [11];
   initial for (int i = 0; i < 11; i++) hist[i] = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!resetn) begin
         for (int i = 0; i < 11; i++) hist[i] <= '0;
      end else begin
         hist[0] <= {vid_de, vid_hsync, vid_vsync, vid_r, vid_g, vid_b};
         for (int i = 1; i < 11; i++) hist[i] <= hist[i-1];
      end
   end

   int tests = 0, fails = 0;

   // Reference state (bench-side blank counter and preamble schedule).
   int   m_blank = 0;
   logic m_prev = 1'b0;
   int   pre_at = -100;
   logic err_exp = 1'b0, err_nxt = 1'b0;

   // Window counters for the line under measurement.
   int w_lo = 1 << 30, w_hi = 0;
   int pre_cnt, g_cnt, de_cnt, first_pre, first_g, first_de;

   typedef struct {
      int pre_len;
      int gap;
      int len;
      bit clr;
      int exp_pre;
      int exp_guard;
      bit exp_err;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      logic [26:0] e;
      logic [1:0]  st;
      e = hist[10];
      if (cyc >= pre_at && cyc <= pre_at + 7) st = 2'd1;
      else if (cyc >= pre_at + 8 && cyc <= pre_at + 9) st = 2'd2;
      else st = e[26] ? 2'd3 : 2'd0;
      chk("a_de", a_de, e[26]);
      chk("a_sync", a_ctl[1:0], {e[24], e[25]});
      chk("a_data", {a_d2, a_d1, a_d0}, e[26] ? e[23:0] : 24'd0);
      chk("a_state", a_st, st);
      chk("a_ctl_hi", a_ctl[5:2], (st == 2'd1) ? 4'b0001 : 4'b0000);
      chk("a_guard", a_gv, st == 2'd2);
      chk("a_err", a_err, err_exp);
      chk("v_de", v_de, e[26]);
      chk("v_sync", v_ctl, {4'b0000, e[24], e[25]});
      chk("v_data", {v_d2, v_d1, v_d0}, e[26] ? e[23:0] : 24'd0);
      chk("v_state", v_st, e[26] ? 2'd3 : 2'd0);
      chk("v_guard", v_gv, 1'b0);
      chk("v_err", v_err, 1'b0);
      if (cyc >= w_lo && cyc <= w_hi) begin
         if (a_st == 2'd1) begin
            pre_cnt++;
            if (first_pre < 0) first_pre = cyc;
         end
         if (a_gv) begin
            g_cnt++;
            if (first_g < 0) first_g = cyc;
         end
         if (cyc >= w_lo + 10 && a_de) begin
            de_cnt++;
            if (first_de < 0) first_de = cyc;
         end
      end
   endtask

   task automatic step(input logic rn, input logic de, input logic clr, input logic [7:0] pix,
                       input logic hs, input logic vs);
      logic rise;
      @(posedge clk);
      #1;
      err_exp   = err_nxt;
      resetn    = rn;
      vid_de    = de;
      clr_err   = clr;
      vid_hsync = hs;
      vid_vsync = vs;
      vid_r     = pix;
      vid_g     = pix + 8'd1;
      vid_b     = pix ^ 8'h5A;
      @(negedge clk);
      monitor();
      rise = de & ~m_prev;
      if (!rn) begin
         m_blank = 0;
         m_prev  = 1'b0;
         pre_at  = -100;
         err_nxt = 1'b0;
      end else begin
         if (rise && m_blank >= 12) pre_at = cyc + 1;
         err_nxt = (rise && m_blank < 12) | (err_exp & ~clr);
         m_blank = de ? 0 : (m_blank < 255 ? m_blank + 1 : 255);
         m_prev  = de;
      end
   endtask

   // Random syncs keep enc_ctl[1:0] tracking exercised through preamble and guard windows.
   task automatic stepr(input logic rn, input logic de, input logic clr, input logic [7:0] pix);
      step(rn, de, clr, pix, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic open_window(input int len);
      pre_cnt = 0; g_cnt = 0; de_cnt = 0;
      first_pre = -1; first_g = -1; first_de = -1;
      w_lo = cyc + 2;
      w_hi = w_lo + len + 14;
   endtask

   task automatic measured_line(input int len, input int exp_pre, input int exp_g,
                                input string tag);
      open_window(len);
      for (int i = 0; i < len; i++) stepr(1'b1, 1'b1, 1'b0, 8'(i * 7 + 3));
      for (int i = 0; i < 20; i++) stepr(1'b1, 1'b0, 1'b0, 8'd0);
      chk({tag, "_pre_cnt"}, pre_cnt, exp_pre);
      chk({tag, "_guard_cnt"}, g_cnt, exp_g);
      chk({tag, "_de_cnt"}, de_cnt, len);
      chk({tag, "_first_de"}, first_de, w_lo + 10);
      if (exp_pre != 0) begin
         chk({tag, "_first_pre"}, first_pre, w_lo);
         chk({tag, "_first_guard"}, first_g, w_lo + 8);
      end
   endtask

   initial begin
      tbl[0] = '{pre_len: 0,  gap: 20, len: 16, clr: 1'b0, exp_pre: 8, exp_guard: 2, exp_err: 1'b0};
      tbl[1] = '{pre_len: 16, gap: 5,  len: 16, clr: 1'b0, exp_pre: 0, exp_guard: 0, exp_err: 1'b1};
      tbl[2] = '{pre_len: 16, gap: 12, len: 10, clr: 1'b1, exp_pre: 8, exp_guard: 2, exp_err: 1'b0};
      tbl[3] = '{pre_len: 16, gap: 11, len: 8,  clr: 1'b0, exp_pre: 0, exp_guard: 0, exp_err: 1'b1};
      tbl[4] = '{pre_len: 0,  gap: 30, len: 1,  clr: 1'b1, exp_pre: 8, exp_guard: 2, exp_err: 1'b0};
      tbl[5] = '{pre_len: 12, gap: 10, len: 4,  clr: 1'b0, exp_pre: 0, exp_guard: 0, exp_err: 1'b1};

      // Reset state
      for (int i = 0; i < 3; i++) stepr(1'b0, 1'b0, 1'b0, 8'd0);
      chk("rst_state", a_st, 2'd0);
      chk("rst_outs", {a_de, a_gv, a_err, a_ctl, a_d0, a_d1, a_d2}, '0);
      chk("guard_sym", {a_s0, a_s1, a_s2}, {10'b1011001100, 10'b0100110011, 10'b1011001100});
      chk("guard_sym_dvi", {v_s0, v_s1, v_s2},
          {10'b1011001100, 10'b0100110011, 10'b1011001100});

      // Table-driven line scenarios
      for (int t = 0; t < 6; t++) begin
         if (tbl[t].clr) stepr(1'b1, 1'b0, 1'b1, 8'd0);
         for (int i = 0; i < tbl[t].pre_len; i++) stepr(1'b1, 1'b1, 1'b0, 8'(i));
         for (int i = 0; i < tbl[t].gap; i++) stepr(1'b1, 1'b0, 1'b0, 8'd0);
         measured_line(tbl[t].len, tbl[t].exp_pre, tbl[t].exp_guard, $sformatf("vec%0d", t));
         chk($sformatf("vec%0d_err", t), a_err, tbl[t].exp_err);
      end

      // Clear, then set and clear in the same cycle: set wins.
      stepr(1'b1, 1'b0, 1'b1, 8'd0);
      stepr(1'b1, 1'b0, 1'b0, 8'd0);
      chk("clr_err", a_err, 1'b0);
      for (int i = 0; i < 4; i++) stepr(1'b1, 1'b1, 1'b0, 8'd9);
      for (int i = 0; i < 3; i++) stepr(1'b1, 1'b0, 1'b0, 8'd0);
      stepr(1'b1, 1'b1, 1'b1, 8'd1);
      stepr(1'b1, 1'b1, 1'b0, 8'd2);
      chk("set_wins", a_err, 1'b1);
      stepr(1'b1, 1'b0, 1'b1, 8'd0);
      stepr(1'b1, 1'b0, 1'b0, 8'd0);
      chk("clr_after_set", a_err, 1'b0);

      // Reset during preamble
      for (int i = 0; i < 20; i++) stepr(1'b1, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 3; i++) stepr(1'b1, 1'b1, 1'b0, 8'(i));
      chk("pre_before_rst", a_st, 2'd1);
      stepr(1'b0, 1'b0, 1'b0, 8'd0);
      stepr(1'b1, 1'b0, 1'b0, 8'd0);
      chk("rst_mid_state", a_st, 2'd0);
      chk("rst_mid_outs", {a_de, a_gv, a_err, a_ctl, a_d0, a_d1, a_d2}, '0);
      for (int i = 0; i < 12; i++) stepr(1'b1, 1'b0, 1'b0, 8'd0);
      measured_line(8, 8, 2, "after_rst");

      // Reduced frame; the DVI instance is checked every cycle by the monitor.
      for (int ln = 0; ln < 28; ln++) begin
         for (int x = 0; x < 50; x++) begin
            step(1'b1, (x < 32) && (ln < 24), 1'b0, 8'(x + ln),
                 (x >= 36) && (x < 41), (ln == 25) || (ln == 26));
         end
      end
      for (int i = 0; i < 15; i++) stepr(1'b1, 1'b0, 1'b0, 8'd0);
      chk("frame_err_dvi", v_err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
